seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_pkg.sv | 19 +
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seven_seg_scan.sv | 117 +++++++++++
 tb/tb_seven_seg_scan.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 produce a dark digit.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] code_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with registered, active-low seg/an outputs.
// Define SEVEN_SEG_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                          blank,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [IdxW-1:0]               digit_idx,
  output logic                          invalid
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam int unsigned RegW = DIGIT_W * NUM_DIGITS;

  logic [DivW-1:0]       div_q, div_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [RegW-1:0]       disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  invalid_q, invalid_d;

  logic                  slot_end;
  logic [DIGIT_W-1:0]    cur_code;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_dec;
  logic                  bad_any;
  logic                  hide;

  always_comb begin
    slot_end = (div_q == DivW'(REFRESH_DIV - 1));
    div_d    = slot_end ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    disp_d = load ? bcd_in : disp_q;
  end

  // Outputs are built from the current (pre-edge) index and display register.
  always_comb begin
    cur_code = '0;
    an_sel   = '1;
    bad_any  = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code  = disp_q[DIGIT_W*i +: DIGIT_W];
        an_sel[i] = 1'b0;
      end
      if (disp_q[DIGIT_W*i +: DIGIT_W] > 4'd9) begin
        bad_any = 1'b1;
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .code_i (cur_code),
    .seg_o  (seg_dec)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_run = zero_run & (disp_q[DIGIT_W*i +: DIGIT_W] == '0);
      lz[i]    = zero_run;
    end
  end

  assign hide = blank | (|(lz & ~an_sel));
`else
  assign hide = blank;
`endif

  always_comb begin
    seg_d     = hide ? SEG_OFF : seg_dec;
    an_d      = hide ? '1 : an_sel;
    invalid_d = bad_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      seg_q     <= SEG_OFF;
      an_q      <= '1;
      invalid_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      invalid_q <= invalid_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised self-checking bench for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4).
// The reference derives slot/index from an edge count and decodes from a lookup table.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        invalid;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: edges since reset release and the display register value.
  int          m_edges = 0;
  logic [15:0] m_disp  = '0;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic [1:0]  exp_idx;
  logic        exp_inv;

  seven_seg_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bcd_in    (bcd_in),
    .blank     (blank),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required finish", $time);
    $fatal(1);
  end

  function automatic logic [6:0] pattern(input logic [3:0] c);
    if (c <= 4'd9) return SEG_TBL[int'(c)];
    return 7'b1111111;
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    logic [15:0] t;
    for (int i = 0; i < ND; i++) begin
      t = v >> (4 * i);
      if (t[3:0] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one cycle and compute what the outputs must be after the edge.
  task automatic step(input logic ld, input logic [15:0] val, input logic blk);
    int          pi;
    logic [15:0] sh;
    logic        dark;
    load   = ld;
    bcd_in = val;
    blank  = blk;
    pi     = (m_edges / RD) % ND;
    sh     = m_disp >> (4 * pi);
    dark   = blk;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (pi > 0 && sh == 16'h0) dark = 1'b1;
`endif
    exp_inv = has_bad(m_disp);
    exp_seg = dark ? 7'b1111111 : pattern(sh[3:0]);
    exp_an  = dark ? 4'b1111 : ~(4'b0001 << pi);
    if (ld) m_disp = val;
    m_edges++;
    exp_idx = 2'((m_edges / RD) % ND);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v = '0;
    for (int i = 0; i < ND; i++) begin
      v = v | (16'($urandom_range(0, 9)) << (4 * i));
    end
    if ($urandom_range(0, 3) == 0) v = 16'($urandom);
    if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({seg, an, digit_idx, invalid} !== {7'b1111111, 4'b1111, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got seg=%b an=%b idx=%0d inv=%b, required 1111111 1111 0 0",
               seg, an, digit_idx, invalid);
    end
    rst     = 1'b0;
    m_edges = 0;
    m_disp  = '0;
    step(1'b0, 16'h0, 1'b0);
    tests_run++;
    if (seg !== 7'b1000000 || an[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_cycle: got seg=%b an=%b, required seg=1000000 an[0]=0", seg, an);
    end
  endtask

  task automatic test_scan();
    step(1'b1, 16'h1234, 1'b0);
    for (int c = 0; c < 24; c++) begin
      step(1'b0, 16'h0, 1'b0);
      tests_run++;
      if ({an, seg, digit_idx, invalid} !== {exp_an, exp_seg, exp_idx, exp_inv}) begin
        tests_failed++;
        $display("FAIL scan c=%0d: got an=%b seg=%b idx=%0d inv=%b, required %b %b %0d %b",
                 c, an, seg, digit_idx, invalid, exp_an, exp_seg, exp_idx, exp_inv);
      end
    end
  endtask

  task automatic test_invalid();
    step(1'b1, 16'h00A5, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    tests_run++;
    if (invalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL invalid_set: got %b, required 1", invalid);
    end
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 16'h0, 1'b0);
      tests_run++;
      if ({an, seg, digit_idx, invalid} !== {exp_an, exp_seg, exp_idx, exp_inv}) begin
        tests_failed++;
        $display("FAIL invalid_scan c=%0d: got an=%b seg=%b idx=%0d inv=%b, required %b %b %0d %b",
                 c, an, seg, digit_idx, invalid, exp_an, exp_seg, exp_idx, exp_inv);
      end
    end
    step(1'b1, 16'h0005, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    tests_run++;
    if (invalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_clear: got %b, required 0", invalid);
    end
  endtask

  task automatic test_leading_zero();
    step(1'b1, 16'h0007, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 16'h0, 1'b0);
      tests_run++;
      if ({an, seg, digit_idx} !== {exp_an, exp_seg, exp_idx}) begin
        tests_failed++;
        $display("FAIL lz c=%0d: got an=%b seg=%b idx=%0d, required %b %b %0d",
                 c, an, seg, digit_idx, exp_an, exp_seg, exp_idx);
      end
    end
  endtask

  task automatic test_blank();
    step(1'b1, 16'h8888, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 16'h0, 1'b1);
      tests_run++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || digit_idx !== exp_idx) begin
        tests_failed++;
        $display("FAIL blank c=%0d: got an=%b seg=%b idx=%0d, required 1111 1111111 %0d",
                 c, an, seg, digit_idx, exp_idx);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 16'h0, 1'b0);
      tests_run++;
      if ({an, seg, digit_idx} !== {exp_an, 7'b0000000, exp_idx}) begin
        tests_failed++;
        $display("FAIL unblank c=%0d: got an=%b seg=%b idx=%0d, required %b 0000000 %0d",
                 c, an, seg, digit_idx, exp_an, exp_idx);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    int guard = 0;
    step(1'b1, 16'h00A5, 1'b0);
    while ((m_edges % (RD * ND)) != (2 * RD + 1) && guard < 40) begin
      step(1'b0, 16'h0, 1'b0);
      guard++;
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({seg, an, digit_idx, invalid} !== {7'b1111111, 4'b1111, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_async: got seg=%b an=%b idx=%0d inv=%b, required 1111111 1111 0 0",
               seg, an, digit_idx, invalid);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_edges = 0;
    m_disp  = '0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 16'h0, 1'b0);
      tests_run++;
      if ({an, seg, digit_idx, invalid} !== {exp_an, exp_seg, exp_idx, exp_inv}) begin
        tests_failed++;
        $display("FAIL reset_resume c=%0d: got an=%b seg=%b idx=%0d inv=%b, required %b %b %0d %b",
                 c, an, seg, digit_idx, invalid, exp_an, exp_seg, exp_idx, exp_inv);
      end
    end
    tests_run++;
    if (digit_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL reset_advance: got idx=%0d, required 1", digit_idx);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    while ((m_edges % (RD * ND)) != (RD - 1) && guard < 40) begin
      step(1'b0, 16'h0, 1'b0);
      guard++;
    end
    step(1'b1, 16'h9999, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    tests_run++;
    if (an !== 4'b1101 || seg !== 7'b0010000) begin
      tests_failed++;
      $display("FAIL load_at_advance: got an=%b seg=%b, required 1101 0010000", an, seg);
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic        blk;
    logic [15:0] v;
    for (int c = 0; c < 300; c++) begin
      ld  = ($urandom_range(0, 5) == 0);
      blk = ($urandom_range(0, 9) == 0);
      v   = rand_bcd();
      step(ld, v, blk);
      tests_run++;
      if ({an, seg, digit_idx, invalid} !== {exp_an, exp_seg, exp_idx, exp_inv}) begin
        tests_failed++;
        $display("FAIL random c=%0d: got an=%b seg=%b idx=%0d inv=%b, required %b %b %0d %b",
                 c, an, seg, digit_idx, invalid, exp_an, exp_seg, exp_idx, exp_inv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_invalid();
    test_leading_zero();
    test_blank();
    test_reset_mid_slot();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
